// File: rtl/noc_buffer_pkg.sv
// Shared defaults and width helpers for the router input buffer.
package noc_buffer_pkg;

  localparam int FLIT_SIZE_DEF   = 8;
  localparam int BUFFER_SIZE_DEF = 8;
  localparam int VC_NUM_DEF      = 2;

  // Ceiling log2. clogb2(1) = 0, clogb2(2) = 1, clogb2(5) = 3.
  function automatic int clogb2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  // The VC selector is at least one bit wide, even when there is only one VC.
  function automatic int vc_sel_width(input int vc_num);
    return (clogb2(vc_num) < 1) ? 1 : clogb2(vc_num);
  endfunction

  // The count has to hold the value BUFFER_SIZE itself.
  function automatic int cnt_width(input int buffer_size);
    return clogb2(buffer_size + 1);
  endfunction

endpackage

// File: rtl/vc_fifo_slice.sv
// One virtual channel's circular FIFO.
// Holds the storage, pointers, registered count, sticky error bit and credit register.
module vc_fifo_slice
  import noc_buffer_pkg::*;
#(
  parameter int BUFFER_SIZE = BUFFER_SIZE_DEF,
  parameter int FLIT_SIZE   = FLIT_SIZE_DEF,
  parameter int CNT_W       = cnt_width(BUFFER_SIZE_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 is_empty_o,
  output logic                 is_full_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 credit_o,
  output logic                 error_o
);

  localparam int                PTR_W      = clogb2(BUFFER_SIZE);
  localparam logic [PTR_W-1:0]  LAST_SLOT  = PTR_W'(BUFFER_SIZE - 1);
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(BUFFER_SIZE);

  logic [FLIT_SIZE-1:0] mem [BUFFER_SIZE];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 empty;
  logic                 full;
  logic                 do_write;
  logic                 do_read;
  logic                 bad_access;

  // A read on an empty FIFO is ignored.
  // A write on a full FIFO is accepted only when a pop frees a slot in the same cycle.
  always_comb begin
    empty      = (count == '0);
    full       = (count == FULL_COUNT);
    do_read    = rd_en && !empty;
    do_write   = wr_en && (!full || rd_en);
    bad_access = (wr_en && full && !rd_en) || (rd_en && empty);
  end

  assign is_empty_o = empty;
  assign is_full_o  = full;
  assign count_o    = count;
  assign data_o     = mem[rd_ptr];

  // Flit storage has no reset; its contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= data_i;
  end

  // Pointers wrap explicitly, so BUFFER_SIZE need not be a power of two.
  // The count moves only when exactly one side is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      credit_o <= 1'b0;
      error_o  <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
      if (do_read)  rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
      if (do_write && !do_read)      count <= count + 1'b1;
      else if (do_read && !do_write) count <= count - 1'b1;
      credit_o <= do_read;
      if (bad_access) error_o <= 1'b1;
    end
  end

endmodule

// File: rtl/vc_input_buffer.sv
// Router input-port buffer: VC_NUM independent FIFO slices behind one shared write port.
module vc_input_buffer
  import noc_buffer_pkg::*;
#(
  parameter int BUFFER_SIZE = BUFFER_SIZE_DEF,
  parameter int FLIT_SIZE   = FLIT_SIZE_DEF,
  parameter int VC_NUM      = VC_NUM_DEF,
  parameter int VC_SEL_W    = vc_sel_width(VC_NUM),
  parameter int CNT_W       = cnt_width(BUFFER_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FLIT_SIZE-1:0]        data_i,
  input  logic                        write_i,
  input  logic [VC_SEL_W-1:0]         vc_sel_i,
  input  logic [VC_NUM-1:0]           read_i,
  output logic [VC_NUM*FLIT_SIZE-1:0] data_o,
  output logic [VC_NUM-1:0]           is_empty_o,
  output logic [VC_NUM-1:0]           is_full_o,
  output logic [VC_NUM*CNT_W-1:0]     count_o,
  output logic [VC_NUM-1:0]           credit_o,
  output logic [VC_NUM-1:0]           error_o
);

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    logic wr_en;

    // If vc_sel_i names no existing VC, no slice is enabled.
    // The write is then silently dropped.
    assign wr_en = write_i && (vc_sel_i == VC_SEL_W'(v));

    vc_fifo_slice #(
      .BUFFER_SIZE (BUFFER_SIZE),
      .FLIT_SIZE   (FLIT_SIZE),
      .CNT_W       (CNT_W)
    ) u_slice (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .rd_en      (read_i[v]),
      .data_i     (data_i),
      .data_o     (data_o[v*FLIT_SIZE +: FLIT_SIZE]),
      .is_empty_o (is_empty_o[v]),
      .is_full_o  (is_full_o[v]),
      .count_o    (count_o[v*CNT_W +: CNT_W]),
      .credit_o   (credit_o[v]),
      .error_o    (error_o[v])
    );
  end

endmodule

// File: tb/tb_vc_input_buffer.sv
// Self-checking bench for vc_input_buffer.
// Uses a 5-slot, 3-VC configuration so that pointer wrap and the out-of-range selector are both exercised.
module tb_vc_input_buffer;

  localparam int BS = 5;
  localparam int FS = 8;
  localparam int VN = 3;
  localparam int SW = 2;
  localparam int CW = 3;

  logic              clk;
  logic              rst;
  logic [FS-1:0]     data_i;
  logic              write_i;
  logic [SW-1:0]     vc_sel_i;
  logic [VN-1:0]     read_i;
  logic [VN*FS-1:0]  data_o;
  logic [VN-1:0]     is_empty_o;
  logic [VN-1:0]     is_full_o;
  logic [VN*CW-1:0]  count_o;
  logic [VN-1:0]     credit_o;
  logic [VN-1:0]     error_o;

  logic [FS-1:0]     sb [VN][$];
  logic [VN-1:0]     exp_err;
  logic [VN-1:0]     exp_credit;
  int                check_cnt;
  int                fail_cnt;

  vc_input_buffer #(
    .BUFFER_SIZE (BS),
    .FLIT_SIZE   (FS),
    .VC_NUM      (VN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .write_i    (write_i),
    .vc_sel_i   (vc_sel_i),
    .read_i     (read_i),
    .data_o     (data_o),
    .is_empty_o (is_empty_o),
    .is_full_o  (is_full_o),
    .count_o    (count_o),
    .credit_o   (credit_o),
    .error_o    (error_o)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int v, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s vc%0d observed=0x%0h expected=0x%0h", tag, v, obs, exp);
    end
  endtask

  task automatic checkState();
    for (int v = 0; v < VN; v++) begin
      checkOutput("count", v, 32'(count_o[v*CW +: CW]), 32'(sb[v].size()));
      checkOutput("empty", v, 32'(is_empty_o[v]), 32'(sb[v].size() == 0));
      checkOutput("full", v, 32'(is_full_o[v]), 32'(sb[v].size() == BS));
      checkOutput("error", v, 32'(error_o[v]), 32'(exp_err[v]));
      checkOutput("credit", v, 32'(credit_o[v]), 32'(exp_credit[v]));
      if (sb[v].size() > 0)
        checkOutput("head", v, 32'(data_o[v*FS +: FS]), 32'(sb[v][0]));
    end
  endtask

  // Drives one cycle of stimulus and updates the scoreboard with what the buffer should accept.
  // It then steps past the edge and checks all outputs.
  task automatic applyStimulus(input logic wr, input logic [SW-1:0] sel, input logic [FS-1:0] data,
                               input logic [VN-1:0] rd);
    int n;
    logic w;
    write_i  = wr;
    vc_sel_i = sel;
    data_i   = data;
    read_i   = rd;
    for (int v = 0; v < VN; v++) begin
      w = wr && (sel == SW'(v));
      n = sb[v].size();
      exp_credit[v] = 1'b0;
      if (rd[v]) begin
        if (n > 0) begin
          checkOutput("pop_data", v, 32'(data_o[v*FS +: FS]), 32'(sb[v][0]));
          void'(sb[v].pop_front());
          exp_credit[v] = 1'b1;
        end else begin
          exp_err[v] = 1'b1;
        end
      end
      if (w) begin
        if (n < BS || rd[v]) sb[v].push_back(data);
        else exp_err[v] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    write_i = 1'b0;
    read_i  = '0;
    checkState();
  endtask

  initial begin
    check_cnt  = 0;
    fail_cnt   = 0;
    exp_err    = '0;
    exp_credit = '0;
    rst        = 1'b1;
    write_i    = 1'b0;
    vc_sel_i   = '0;
    data_i     = '0;
    read_i     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    $display("[TB] reset state");
    checkState();

    $display("[TB] fill VC0 to full");
    for (int i = 0; i < BS; i++) applyStimulus(1'b1, 2'd0, 8'h11 + 8'(i), 3'b000);

    $display("[TB] read+write on full VC0");
    applyStimulus(1'b1, 2'd0, 8'h20, 3'b001);

    $display("[TB] overflow write on VC0");
    applyStimulus(1'b1, 2'd0, 8'h16, 3'b000);

    $display("[TB] read+write on empty VC1");
    applyStimulus(1'b1, 2'd1, 8'h30, 3'b010);

    $display("[TB] pop VC0 and VC1 while writing VC1");
    applyStimulus(1'b1, 2'd1, 8'h31, 3'b011);

    $display("[TB] drain VC0 back to back");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'd0, 8'h00, 3'b001);
    applyStimulus(1'b0, 2'd0, 8'h00, 3'b000);

    $display("[TB] wrap test on VC2");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd2, 8'hA0 + 8'(i), 3'b000);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 2'd2, 8'hA3 + 8'(i), 3'b100);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'd0, 8'h00, 3'b100);

    $display("[TB] underflow on VC2");
    applyStimulus(1'b0, 2'd0, 8'h00, 3'b100);

    $display("[TB] write to nonexistent VC");
    applyStimulus(1'b1, 2'd3, 8'hEE, 3'b000);

    $display("[TB] asynchronous reset with VCs half full");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'd0, 8'h40 + 8'(i), 3'b000);
      applyStimulus(1'b1, 2'd1, 8'h50 + 8'(i), 3'b000);
    end
    applyStimulus(1'b0, 2'd0, 8'h00, 3'b001);
    #3;
    rst = 1'b1;
    #1;
    for (int v = 0; v < VN; v++) sb[v].delete();
    exp_err    = '0;
    exp_credit = '0;
    checkState();
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkState();

    $display("[TB] write after reset");
    applyStimulus(1'b1, 2'd0, 8'h55, 3'b000);
    applyStimulus(1'b0, 2'd0, 8'h00, 3'b001);

    $display("%0d/%0d checks passed", check_cnt - fail_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/vc_input_buffer.md
# vc_input_buffer

Multi-virtual-channel input buffer for a router input port. It holds one independent circular FIFO per virtual channel (VC) behind a single shared write port. It also provides:
- per-VC occupancy,
- credit return toward the upstream router,
- sticky overflow/underflow error flags.

It sits between the link receiver and the route-computation/VC-allocation stages.

## Interface
- BUFFER_SIZE, 8, flit slots per VC; any value ≥2, not required to be a power of two
- FLIT_SIZE, 8, flit width in bits
- VC_NUM, 2, number of virtual channels; ≥1
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- data_i  in  FLIT_SIZE  incoming flit
- write_i  in  1  write strobe for data_i
- vc_sel_i  in  VC_SEL_W  target VC of the write; VC_SEL_W = max(1, clog2(VC_NUM))
- read_i  in  VC_NUM  per-VC read (pop) strobes; several may be high at once
- data_o  out  VC_NUM×FLIT_SIZE  head flit of each VC, first-word-fall-through
- is_empty_o  out  VC_NUM  per-VC empty flag
- is_full_o  out  VC_NUM  per-VC full flag
- count_o  out  VC_NUM×CNT_W  per-VC occupancy; CNT_W = clog2(BUFFER_SIZE+1)
- credit_o  out  VC_NUM  one-cycle pulse per flit popped from that VC
- error_o  out  VC_NUM  sticky: overflow or underflow seen on that VC

## Operation
Reset (asynchronous) puts every output in this state:
- all pointers and counts 0
- is_empty_o all 1
- is_full_o, credit_o, error_o all 0
- memory contents undefined; data_o is don't-care while empty

Per-VC pointer behaviour:
- Read and write pointers are in range 0..BUFFER_SIZE-1.
- Each increments with explicit wrap from BUFFER_SIZE-1 to 0.
- Flags and count are derived from a registered count, not from pointer comparison.
- is_full_o = (count == BUFFER_SIZE); is_empty_o = (count == 0).

Events per VC per cycle:
- Write: write_i and vc_sel_i == v.
- Read: read_i[v].

Outcome of each case:
- Write only, not full: store flit at the write pointer, advance the write pointer, count +1.
- Write only, full: flit dropped; state unchanged; error_o[v] set.
- Read only, not empty: advance the read pointer, count −1, credit pulse.
- Read only, empty: ignored; error_o[v] set.
- Read+write, not empty (full included): both accepted; count unchanged; credit pulse.
- Read+write, empty: write accepted, read ignored; count becomes 1; error_o[v] set; no credit.

Other rules:
- vc_sel_i ≥ VC_NUM while write_i is high: write dropped; no flag set.
- error_o is cleared only by rst.
- VCs are fully independent. Reads on several VCs in the same cycle each complete, and each VC pulses its own credit.

## Timing
- Write-to-visible latency is 1 cycle. A flit written at edge N appears on data_o and count_o after edge N, and is_empty_o falls at the same time.
- data_o[v] is combinational from memory at the read pointer, so there is no read latency. The next head flit is valid immediately after the popping edge.
- credit_o[v] is registered and is high for exactly the cycle after each accepted pop. Back-to-back pops give a continuous high.
- Flags, count and error_o are registered and update on the same edge as the pointers.
- rst asserted mid-operation empties every VC immediately, regardless of clk. Credits for flits discarded this way are not returned; the upstream side resets together with this block.

## Structure
- Package noc_buffer_pkg holds:
  - the clogb2 function,
  - localparam helpers for VC_SEL_W and CNT_W,
  - the shared FLIT_SIZE/BUFFER_SIZE/VC_NUM defaults.
- One sub-module, vc_fifo_slice, contains one VC's storage, pointers, count, flags, error bit and credit register.
  - Its inputs are a write enable, a read enable and the flit.
  - The top level is a generate loop of VC_NUM slices plus decoding of vc_sel_i into per-slice write enables.

## Test plan
- BUFFER_SIZE=8, VC_NUM=2. Write 0x11..0x18 to VC0, then one more write (0x19) → is_full_o[0]=1 after the 8th write, count_o[0]=8, 0x19 dropped, error_o[0]=1, VC1 unaffected.
- Continue from the full VC0: pop 8 → data_o[0] reads 0x11..0x18 in order, credit_o[0] gives 8 consecutive pulses, each one cycle behind its pop, is_empty_o[0]=1 at the end.
- BUFFER_SIZE=5: push and pop 13 flits with a steady depth of 3 → pointers wrap correctly and the output order is preserved.
- VC0 full: read and write in the same cycle → new flit accepted, count stays 5 (BUFFER_SIZE=5), no error. VC1 empty: read and write in the same cycle → count_o[1]=1, error_o[1]=1, no credit.
- Pop VC0 and VC1 in the same cycle while writing VC1 → both credits pulse, count_o[0] −1, count_o[1] unchanged.
- Assert rst asynchronously between edges with both VCs half full → all outputs return to reset values immediately, error_o cleared.
